// File: rtl/axil_reg_pkg.sv
// ----------------------------------------------------------------------------
// axil_reg_pkg
// Shared types and constants for the AXI4-Lite to register-strobe bridge.
//   - wrState_t / rdState_t : write and read channel FSM states
//   - RESP_OKAY / RESP_SLVERR : AXI response codes
//   - REG_ADDR_W / REG_DATA_W : register bus address and data widths
//   - isMisaligned() : true when an address is not 8-byte aligned
// ----------------------------------------------------------------------------
package axil_reg_pkg;

   localparam int REG_ADDR_W = 16;
   localparam int REG_DATA_W = 64;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE,
      W_ISSUE,
      W_RESP
   } wrState_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_ISSUE,
      R_WAIT,
      R_RESP
   } rdState_t;

   // Registers are 64 bits wide, so a legal access has the three low
   // address bits clear.
   function automatic logic isMisaligned(input logic [REG_ADDR_W-1:0] addr);
      return (addr[2:0] != 3'b000);
   endfunction

endpackage

// File: rtl/axil_reg_bridge_if.sv
// ----------------------------------------------------------------------------
// axil_reg_bridge_if
// AXI4-Lite bundle (64-bit data) between the PS master and the bridge.
//   Parameter ADDR_W : address width of AW/AR channels.
//   AW : awaddr, awvalid, awready
//   W  : wdata, wstrb, wvalid, wready
//   B  : bresp, bvalid, bready
//   AR : araddr, arvalid, arready
//   R  : rdata, rresp, rvalid, rready
//   Modports: master (PS side), slave (bridge side).
// ----------------------------------------------------------------------------
interface axil_reg_bridge_if #(
   parameter int ADDR_W = 16
) ();
   import axil_reg_pkg::*;

   logic [ADDR_W-1:0]       awaddr;
   logic                    awvalid;
   logic                    awready;
   logic [REG_DATA_W-1:0]   wdata;
   logic [REG_DATA_W/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_W-1:0]       araddr;
   logic                    arvalid;
   logic                    arready;
   logic [REG_DATA_W-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/axil_reg_bridge.sv
// ----------------------------------------------------------------------------
// axil_reg_bridge
// AXI4-Lite slave that converts PS register accesses into the single-cycle
// strobe bus of the TLK2711 register manager. Write and read channels are
// independent, each with one transaction in flight.
//
// Parameters:
//   AXI_ADDR_WIDTH : AXI address width (>= 16); only bits [15:0] reach the bus
//   RD_LATENCY     : cycles from the o_reg_ren pulse to the cycle in which
//                    i_reg_rdata is sampled (1..255)
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   s_axil        : AXI4-Lite slave bundle (axil_reg_bridge_if.slave)
//   o_reg_wen     : one-cycle write strobe, with o_reg_waddr / o_reg_wdata
//   o_reg_ren     : one-cycle read strobe, with o_reg_raddr
//   i_reg_rdata   : read data returned by the register manager
// Build option:
//   AXIL_REG_ALIGN_CHECK_EN : when defined, accesses with addr[2:0] != 0 are
//                             answered with SLVERR and never reach the bus.
// ----------------------------------------------------------------------------
module axil_reg_bridge
   import axil_reg_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 16,
   parameter int RD_LATENCY     = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   axil_reg_bridge_if.slave      s_axil,
   output logic                  o_reg_wen,
   output logic [REG_ADDR_W-1:0] o_reg_waddr,
   output logic [REG_DATA_W-1:0] o_reg_wdata,
   output logic                  o_reg_ren,
   output logic [REG_ADDR_W-1:0] o_reg_raddr,
   input  logic [REG_DATA_W-1:0] i_reg_rdata
);

`ifdef AXIL_REG_ALIGN_CHECK_EN
   localparam bit ALIGN_CHECK = 1'b1;
`else
   localparam bit ALIGN_CHECK = 1'b0;
`endif

   // The wait counter starts at RD_LATENCY-1 so that the capture lands
   // exactly RD_LATENCY cycles after the read strobe.
   localparam logic [7:0] RD_CNT_INIT = 8'(RD_LATENCY - 1);

   // ---------------------------------------------------------------- write
   wrState_t                r_wrState;
   wrState_t                w_wrNext;
   logic                    r_awLatched;
   logic                    r_wLatched;
   logic [REG_ADDR_W-1:0]   r_awAddr;
   logic [REG_DATA_W-1:0]   r_wData;
   logic [REG_DATA_W/8-1:0] r_wStrb;
   logic [REG_ADDR_W-1:0]   r_regWaddr;
   logic [REG_DATA_W-1:0]   r_regWdata;
   logic [1:0]              r_bResp;
   logic                    w_awReady;
   logic                    w_wReady;
   logic                    w_awHs;
   logic                    w_wHs;
   logic                    w_bHs;
   logic                    w_wrStart;
   logic                    w_wrOk;

   assign w_awHs    = s_axil.awvalid & w_awReady;
   assign w_wHs     = s_axil.wvalid & w_wReady;
   assign w_bHs     = (r_wrState == W_RESP) & s_axil.bready;
   assign w_wrStart = (r_wrState == W_IDLE) & r_awLatched & r_wLatched;
   assign w_wrOk    = (r_wStrb == '1) & ~(ALIGN_CHECK & isMisaligned(r_awAddr));

   // Write FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrState <= W_IDLE;
      end else begin
         r_wrState <= w_wrNext;
      end
   end

   // Write FSM next state and strobes. AW and W are only accepted while idle,
   // which also keeps both readies low while a response is pending.
   always_comb begin
      w_wrNext  = r_wrState;
      w_awReady = 1'b0;
      w_wReady  = 1'b0;
      o_reg_wen = 1'b0;
      case (r_wrState)
         W_IDLE: begin
            w_awReady = ~r_awLatched;
            w_wReady  = ~r_wLatched;
            if (w_wrStart) begin
               w_wrNext = W_ISSUE;
            end
         end
         W_ISSUE: begin
            o_reg_wen = w_wrOk;
            w_wrNext  = W_RESP;
         end
         W_RESP: begin
            if (s_axil.bready) begin
               w_wrNext = W_IDLE;
            end
         end
         default: w_wrNext = W_IDLE;
      endcase
   end

   // Write address/data capture. Each channel is latched on its own handshake;
   // the bus address/data registers are loaded on entry to W_ISSUE so they are
   // valid alongside the strobe and otherwise keep the last issued values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_awLatched <= 1'b0;
         r_wLatched  <= 1'b0;
         r_awAddr    <= '0;
         r_wData     <= '0;
         r_wStrb     <= '0;
         r_regWaddr  <= '0;
         r_regWdata  <= '0;
         r_bResp     <= RESP_OKAY;
      end else begin
         if (w_awHs) begin
            r_awLatched <= 1'b1;
            r_awAddr    <= s_axil.awaddr[REG_ADDR_W-1:0];
         end
         if (w_wHs) begin
            r_wLatched <= 1'b1;
            r_wData    <= s_axil.wdata;
            r_wStrb    <= s_axil.wstrb;
         end
         if (w_wrStart && w_wrOk) begin
            r_regWaddr <= r_awAddr;
            r_regWdata <= r_wData;
         end
         if (r_wrState == W_ISSUE) begin
            r_bResp <= w_wrOk ? RESP_OKAY : RESP_SLVERR;
         end
         if (w_bHs) begin
            r_awLatched <= 1'b0;
            r_wLatched  <= 1'b0;
         end
      end
   end

   // Readies are masked during reset so every output reads 0 while rst is high.
   assign s_axil.awready = w_awReady & ~rst;
   assign s_axil.wready  = w_wReady & ~rst;
   assign s_axil.bvalid  = (r_wrState == W_RESP);
   assign s_axil.bresp   = r_bResp;
   assign o_reg_waddr    = r_regWaddr;
   assign o_reg_wdata    = r_regWdata;

   // ----------------------------------------------------------------- read
   rdState_t              r_rdState;
   rdState_t              w_rdNext;
   logic                  r_rdErr;
   logic [7:0]            r_cnt;
   logic [REG_DATA_W-1:0] r_rData;
   logic [1:0]            r_rResp;
   logic [REG_ADDR_W-1:0] r_regRaddr;
   logic                  w_arReady;
   logic                  w_arHs;
   logic                  w_arErr;

   assign w_arHs  = s_axil.arvalid & w_arReady;
   assign w_arErr = ALIGN_CHECK & isMisaligned(s_axil.araddr[REG_ADDR_W-1:0]);

   // Read FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdState <= R_IDLE;
      end else begin
         r_rdState <= w_rdNext;
      end
   end

   // Read FSM next state and strobe. A rejected (misaligned) read skips the
   // wait phase because the register manager is never asked for data.
   always_comb begin
      w_rdNext  = r_rdState;
      w_arReady = 1'b0;
      o_reg_ren = 1'b0;
      case (r_rdState)
         R_IDLE: begin
            w_arReady = 1'b1;
            if (s_axil.arvalid) begin
               w_rdNext = R_ISSUE;
            end
         end
         R_ISSUE: begin
            o_reg_ren = ~r_rdErr;
            w_rdNext  = r_rdErr ? R_RESP : R_WAIT;
         end
         R_WAIT: begin
            if (r_cnt == 8'd0) begin
               w_rdNext = R_RESP;
            end
         end
         R_RESP: begin
            if (s_axil.rready) begin
               w_rdNext = R_IDLE;
            end
         end
         default: w_rdNext = R_IDLE;
      endcase
   end

   // Read address capture, latency counter and read data capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdErr    <= 1'b0;
         r_cnt      <= '0;
         r_rData    <= '0;
         r_rResp    <= RESP_OKAY;
         r_regRaddr <= '0;
      end else begin
         if (w_arHs) begin
            r_rdErr <= w_arErr;
            if (!w_arErr) begin
               r_regRaddr <= s_axil.araddr[REG_ADDR_W-1:0];
            end
         end
         if (r_rdState == R_ISSUE) begin
            r_cnt   <= RD_CNT_INIT;
            r_rResp <= r_rdErr ? RESP_SLVERR : RESP_OKAY;
            if (r_rdErr) begin
               r_rData <= '0;
            end
         end
         if (r_rdState == R_WAIT) begin
            if (r_cnt == 8'd0) begin
               r_rData <= i_reg_rdata;
            end else begin
               r_cnt <= r_cnt - 8'd1;
            end
         end
      end
   end

   assign s_axil.arready = w_arReady & ~rst;
   assign s_axil.rvalid  = (r_rdState == R_RESP);
   assign s_axil.rresp   = r_rResp;
   assign s_axil.rdata   = r_rData;
   assign o_reg_raddr    = r_regRaddr;

endmodule

// File: tb/tb_axil_reg_bridge.sv
// ----------------------------------------------------------------------------
// tb_axil_reg_bridge
// Self-checking bench for axil_reg_bridge. A monitor records every register
// strobe with its cycle number; a responder drives i_reg_rdata with a chosen
// value only in the cycle RD_LAT after each read strobe and random junk in all
// other cycles. Expected latencies, responses and data are derived from the
// transaction rules (handshake cycle + fixed offsets). Honours
// AXIL_REG_ALIGN_CHECK_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_axil_reg_bridge;
   import axil_reg_pkg::*;

   localparam int RD_LAT = 6;
`ifdef AXIL_REG_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   typedef struct {
      int          cyc;
      logic [15:0] addr;
      logic [63:0] data;
   } strobeEv_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        o_reg_wen;
   logic [15:0] o_reg_waddr;
   logic [63:0] o_reg_wdata;
   logic        o_reg_ren;
   logic [15:0] o_reg_raddr;
   logic [63:0] i_reg_rdata;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   strobeEv_t   wenQ[$];
   strobeEv_t   renQ[$];
   logic [63:0] rdPlan[int];
   bit          rdForceUse = 1'b0;
   logic [63:0] rdForceValue;

   axil_reg_bridge_if #(.ADDR_W(16)) s ();

   axil_reg_bridge #(
      .AXI_ADDR_WIDTH(16),
      .RD_LATENCY(RD_LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .s_axil(s),
      .o_reg_wen(o_reg_wen),
      .o_reg_waddr(o_reg_waddr),
      .o_reg_wdata(o_reg_wdata),
      .o_reg_ren(o_reg_ren),
      .o_reg_raddr(o_reg_raddr),
      .i_reg_rdata(i_reg_rdata)
   );

   // Free-running clock and cycle counter; cycle N starts at the Nth rising edge.
   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   // Strobe monitor, sampled mid-cycle. Each read strobe books the data the
   // responder will present RD_LAT cycles later.
   initial forever begin
      @(negedge clk);
      if (o_reg_wen === 1'b1) wenQ.push_back('{cyc, o_reg_waddr, o_reg_wdata});
      if (o_reg_ren === 1'b1) begin
         renQ.push_back('{cyc, o_reg_raddr, 64'h0});
         rdPlan[cyc + RD_LAT] = rdForceUse ? rdForceValue : {$urandom, $urandom};
         rdForceUse = 1'b0;
      end
   end

   // Register-manager responder: booked value in its cycle, junk otherwise.
   initial begin
      i_reg_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         i_reg_rdata = rdPlan.exists(cyc) ? rdPlan[cyc] : {$urandom, $urandom};
      end
   end

   // Hard stop in case something stalls outside the bounded waits.
   initial begin
      #2000000;
      failures++;
      $display("[TB] FAIL watchdog simulation did not finish, required completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic sendAw(input logic [15:0] a, output int hs);
      hs = -1;
      s.awaddr  = a;
      s.awvalid = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (s.awready === 1'b1) begin hs = cyc; break; end
      end
      @(posedge clk); #1;
      s.awvalid = 1'b0;
      if (hs < 0) begin
         checks++; failures++;
         $display("[TB] FAIL aw_handshake awready never seen, required 1");
      end
   endtask

   task automatic sendW(input logic [63:0] d, input logic [7:0] strb, output int hs);
      hs = -1;
      s.wdata  = d;
      s.wstrb  = strb;
      s.wvalid = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (s.wready === 1'b1) begin hs = cyc; break; end
      end
      @(posedge clk); #1;
      s.wvalid = 1'b0;
      if (hs < 0) begin
         checks++; failures++;
         $display("[TB] FAIL w_handshake wready never seen, required 1");
      end
   endtask

   task automatic sendAr(input logic [15:0] a, output int hs);
      hs = -1;
      s.araddr  = a;
      s.arvalid = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (s.arready === 1'b1) begin hs = cyc; break; end
      end
      @(posedge clk); #1;
      s.arvalid = 1'b0;
      if (hs < 0) begin
         checks++; failures++;
         $display("[TB] FAIL ar_handshake arready never seen, required 1");
      end
   endtask

   // One complete write: AW and W launched after their own delays, B accepted
   // after bDly cycles of backpressure, everything checked against the rules.
   task automatic doWrite(input logic [15:0] addr, input logic [63:0] data, input logic [7:0] strb,
                          input int awDly, input int wDly, input int bDly);
      int         awHs, wHs, hs, bCyc, n0;
      bit         ok, stable;
      logic [1:0] expResp;
      ok      = (strb == 8'hFF) && !(ALIGN && addr[2:0] != 3'b000);
      expResp = ok ? RESP_OKAY : RESP_SLVERR;
      n0      = wenQ.size();
      fork
         begin repeat (awDly) @(posedge clk); #1; sendAw(addr, awHs); end
         begin repeat (wDly) @(posedge clk); #1; sendW(data, strb, wHs); end
      join
      hs   = (awHs > wHs) ? awHs : wHs;
      bCyc = -1;
      for (int n = 0; n < 30 && bCyc < 0; n++) begin
         @(negedge clk);
         if (s.bvalid === 1'b1) bCyc = cyc;
      end
      checks++;
      if (bCyc !== hs + 3) begin
         failures++;
         $display("[TB] FAIL bvalid_cycle addr=%h actual=%0d required=%0d", addr, bCyc, hs + 3);
      end
      checks++;
      if (s.bresp !== expResp) begin
         failures++;
         $display("[TB] FAIL bresp addr=%h strb=%h actual=%b required=%b", addr, strb, s.bresp, expResp);
      end
      stable = 1'b1;
      for (int n = 0; n < bDly; n++) begin
         @(negedge clk);
         if (s.bvalid !== 1'b1 || s.bresp !== expResp || s.awready !== 1'b0 || s.wready !== 1'b0) stable = 1'b0;
      end
      checks++;
      if (!stable) begin
         failures++;
         $display("[TB] FAIL b_hold bvalid/bresp/awready/wready not held, actual=0 required=1");
      end
      @(posedge clk); #1; s.bready = 1'b1;
      @(posedge clk); #1; s.bready = 1'b0;
      @(negedge clk);
      checks++;
      if (s.bvalid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL b_release bvalid actual=%b required=0", s.bvalid);
      end
      checks++;
      if (wenQ.size() - n0 !== (ok ? 1 : 0)) begin
         failures++;
         $display("[TB] FAIL wen_count addr=%h actual=%0d required=%0d", addr, wenQ.size() - n0, ok ? 1 : 0);
      end
      if (ok && wenQ.size() > n0) begin
         checks++;
         if (wenQ[n0].cyc !== hs + 2 || wenQ[n0].addr !== addr || wenQ[n0].data !== data) begin
            failures++;
            $display("[TB] FAIL wen_strobe actual cyc=%0d addr=%h data=%h required cyc=%0d addr=%h data=%h",
                     wenQ[n0].cyc, wenQ[n0].addr, wenQ[n0].data, hs + 2, addr, data);
         end
      end
      @(posedge clk); #1;
   endtask

   // One complete read with rDly cycles of R backpressure.
   task automatic doRead(input logic [15:0] addr, input int rDly);
      int          arHs, rCyc, n0, expCyc;
      bit          err, stable;
      logic [1:0]  expResp;
      logic [63:0] expData;
      err     = ALIGN && addr[2:0] != 3'b000;
      expResp = err ? RESP_SLVERR : RESP_OKAY;
      n0      = renQ.size();
      sendAr(addr, arHs);
      expCyc  = err ? arHs + 2 : arHs + RD_LAT + 2;
      rCyc    = -1;
      for (int n = 0; n < RD_LAT + 30 && rCyc < 0; n++) begin
         @(negedge clk);
         if (s.rvalid === 1'b1) rCyc = cyc;
      end
      if (err) expData = '0;
      else if (rdPlan.exists(arHs + 1 + RD_LAT)) expData = rdPlan[arHs + 1 + RD_LAT];
      else expData = 'x;
      checks++;
      if (rCyc !== expCyc) begin
         failures++;
         $display("[TB] FAIL rvalid_cycle addr=%h actual=%0d required=%0d", addr, rCyc, expCyc);
      end
      checks++;
      if (s.rdata !== expData || s.rresp !== expResp) begin
         failures++;
         $display("[TB] FAIL r_payload addr=%h actual data=%h resp=%b required data=%h resp=%b",
                  addr, s.rdata, s.rresp, expData, expResp);
      end
      checks++;
      if (renQ.size() - n0 !== (err ? 0 : 1)) begin
         failures++;
         $display("[TB] FAIL ren_count addr=%h actual=%0d required=%0d", addr, renQ.size() - n0, err ? 0 : 1);
      end
      if (!err && renQ.size() > n0) begin
         checks++;
         if (renQ[n0].cyc !== arHs + 1 || renQ[n0].addr !== addr) begin
            failures++;
            $display("[TB] FAIL ren_strobe actual cyc=%0d addr=%h required cyc=%0d addr=%h",
                     renQ[n0].cyc, renQ[n0].addr, arHs + 1, addr);
         end
      end
      stable = 1'b1;
      for (int n = 0; n < rDly; n++) begin
         @(negedge clk);
         if (s.rvalid !== 1'b1 || s.rdata !== expData || s.rresp !== expResp || s.arready !== 1'b0) stable = 1'b0;
      end
      checks++;
      if (!stable) begin
         failures++;
         $display("[TB] FAIL r_hold rvalid/rdata/rresp/arready not held, actual=0 required=1");
      end
      @(posedge clk); #1; s.rready = 1'b1;
      @(posedge clk); #1; s.rready = 1'b0;
      @(negedge clk);
      checks++;
      if (s.rvalid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL r_release rvalid actual=%b required=0", s.rvalid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({o_reg_wen, o_reg_ren, s.bvalid, s.rvalid, s.awready, s.wready, s.arready} !== 7'b0) begin
         failures++;
         $display("[TB] FAIL reset_ctrl actual=%b required=0000000",
                  {o_reg_wen, o_reg_ren, s.bvalid, s.rvalid, s.awready, s.wready, s.arready});
      end
      checks++;
      if ({o_reg_waddr, o_reg_wdata, o_reg_raddr, s.rdata, s.bresp, s.rresp} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_data waddr=%h wdata=%h raddr=%h rdata=%h required all 0",
                  o_reg_waddr, o_reg_wdata, o_reg_raddr, s.rdata);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({s.awready, s.wready, s.arready} !== 3'b111) begin
         failures++;
         $display("[TB] FAIL idle_ready actual=%b required=111", {s.awready, s.wready, s.arready});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_same_cycle_write();
      doWrite(16'h0028, 64'h1234, 8'hFF, 0, 0, 0);
   endtask

   task automatic test_w_before_aw();
      doWrite(16'h0030, {$urandom, $urandom}, 8'hFF, 5, 0, 10);
   endtask

   task automatic test_read_latency();
      rdForceValue = 64'hA000_0000_0000_003F;
      rdForceUse   = 1'b1;
      doRead(16'h0050, 2);
   endtask

   task automatic test_partial_strobe();
      logic [15:0] lastAddr;
      lastAddr = wenQ[wenQ.size() - 1].addr;
      doWrite(16'h0048, {$urandom, $urandom}, 8'h0F, 0, 0, 1);
      checks++;
      if (o_reg_waddr !== lastAddr) begin
         failures++;
         $display("[TB] FAIL waddr_hold actual=%h required=%h", o_reg_waddr, lastAddr);
      end
   endtask

   task automatic test_concurrent();
      fork
         doWrite(16'h0070, {$urandom, $urandom}, 8'hFF, 0, 0, 2);
         doRead(16'h0038, 1);
      join
   endtask

   task automatic test_reset_mid_read();
      int  arHs;
      bit  sawResp;
      sendAr(16'h0040, arHs);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({o_reg_ren, s.rvalid, o_reg_raddr} !== '0) begin
         failures++;
         $display("[TB] FAIL reset_in_wait ren=%b rvalid=%b raddr=%h required all 0", o_reg_ren, s.rvalid, o_reg_raddr);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      sawResp = 1'b0;
      for (int n = 0; n < RD_LAT + 10; n++) begin
         @(negedge clk);
         if (s.rvalid !== 1'b0) sawResp = 1'b1;
      end
      checks++;
      if (sawResp) begin
         failures++;
         $display("[TB] FAIL abandoned_read rvalid actual=1 required=0");
      end
      @(posedge clk); #1;
      doRead(16'h0058, 0);
      // Reset while the response is being presented must drop it at once.
      sendAr(16'h0060, arHs);
      sawResp = 1'b0;
      for (int n = 0; n < RD_LAT + 10 && !sawResp; n++) begin
         @(negedge clk);
         if (s.rvalid === 1'b1) sawResp = 1'b1;
      end
      rst = 1'b1;
      #1;
      checks++;
      if (!sawResp || s.rvalid !== 1'b0 || s.rdata !== '0) begin
         failures++;
         $display("[TB] FAIL reset_in_resp seen=%b rvalid=%b rdata=%h required seen=1 rvalid=0 rdata=0",
                  sawResp, s.rvalid, s.rdata);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      doRead(16'h0068, 1);
   endtask

   task automatic test_align_check();
      doRead(16'h0024, 0);
      doWrite(16'h002C, {$urandom, $urandom}, 8'hFF, 1, 0, 0);
   endtask

   task automatic test_random();
      logic [15:0] wa, ra;
      logic [7:0]  st;
      for (int i = 0; i < 10; i++) begin
         wa = 16'($urandom);
         ra = 16'($urandom);
         if ($urandom_range(0, 3) != 0) wa[2:0] = 3'b000;
         if ($urandom_range(0, 3) != 0) ra[2:0] = 3'b000;
         st = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
         fork
            doWrite(wa, {$urandom, $urandom}, st, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3));
            doRead(ra, $urandom_range(0, 3));
         join
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) doWrite(16'h0100 + 16'(i * 8), {$urandom, $urandom}, 8'hFF, 0, 0, 0);
      for (int i = 0; i < 3; i++) doRead(16'h0200 + 16'(i * 8), 0);
   endtask

   initial begin
      rst       = 1'b1;
      s.awaddr  = '0;
      s.awvalid = 1'b0;
      s.wdata   = '0;
      s.wstrb   = '0;
      s.wvalid  = 1'b0;
      s.bready  = 1'b0;
      s.araddr  = '0;
      s.arvalid = 1'b0;
      s.rready  = 1'b0;
      test_reset();
      test_same_cycle_write();
      test_w_before_aw();
      test_read_latency();
      test_partial_strobe();
      test_concurrent();
      test_reset_mid_read();
      test_align_check();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
